edac_decoder: RTL and testbench
===============================

Name: edac_decoder

Overview:
Receive-side EDAC stage that consumes the 32-bit codewords produced by the EDAC encoder and recovers the 8-bit payload.
- Computes the Hamming(21,16) syndrome, corrects single-bit errors and extracts the 16-bit {data, CRC} word.
- Re-runs the CRC long division bit-serially and compares it with the received CRC.
- Delivers the data byte, per-word status flags and saturating error counters over a valid/ready handshake.

Parameters:
CNT_W, 16, width of the saturating error counters
DATA_W, 8, payload width (fixed; CRC width equals DATA_W)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
din_valid  in  1  codeword valid
din_ready  out  1  decoder can accept a codeword
din  in  32  codeword; bits 20:0 Hamming word, bits 31:21 ignored
crc_poly  in  8  CRC polynomial, sampled on acceptance
dout_valid  out  1  result valid
dout_ready  in  1  consumer accepts result
dout  out  8  decoded data byte
err_corrected  out  1  nonzero syndrome ≤21, one bit flipped
err_uncorrectable  out  1  syndrome in 22..31, no correction applied
crc_fail  out  1  recomputed CRC differs from received CRC
clr_cnt  in  1  synchronous clear of both counters
cnt_corr  out  CNT_W  count of words with err_corrected
cnt_uncorr  out  CNT_W  count of words with err_uncorrectable or crc_fail

Behaviour:
- Reset: state IDLE, din_ready=1, dout_valid=0, dout=0, all flags 0, counters 0, internal registers 0. The reset takes effect immediately, including mid-decode; a word in flight is discarded.
- Hamming layout: word bit p is Hamming position p+1. Parity bits sit at bits 0,1,3,7,15. Data bits are at 2,4,5,6,8..14,16..20, and map to I[0]..I[15] in ascending order.
- Syndrome: s[4:0] = XOR of (p+1) over every set bit p in din[20:0].
- Correction:
  - s=0: no change.
  - 1≤s≤21: invert bit s-1 and set err_corrected.
  - s≥22: no change and set err_uncorrectable.
- Extracted word: I[15:8] is the data byte, I[7:0] is the received CRC.
- CRC check, identical to the encoder: t={I[15:8],8'h00}. For k=15 down to 8, one k per cycle: if t[k], then t ^= crc_poly<<(k-7). The remainder t[7:0] is compared to I[7:0]; a mismatch sets crc_fail.
- FSM states: IDLE, SYND, CRC, OUT.
  - IDLE: din_ready=1. When din_valid and din_ready, register din[20:0] and crc_poly, go to SYND.
  - SYND: register syndrome, corrected word and flags; load t; step counter=0; go to CRC.
  - CRC: one division step per cycle. After step 7, register crc_fail, go to OUT.
  - OUT: dout_valid=1 with dout and flags stable. When dout_ready, go to IDLE.
- Latency: dout_valid rises 10 clk edges after the accepting edge.
- Throughput: one word per 11 cycles when dout_ready=1. din_ready=0 in SYND, CRC and OUT; there is no skid buffer.
- Handshake: dout, flags and dout_valid are held unchanged while dout_valid=1 and dout_ready=0. din is ignored outside IDLE.
- Uncorrectable words: dout carries the uncorrected data bits, and the CRC check still runs.
- Double errors can be miscorrected. This is expected; crc_fail is the detection mechanism.
- Counters:
  - Update on the OUT→IDLE handshake edge.
  - Saturate at all-ones; no wrap.
  - clr_cnt has priority over a same-cycle increment. A same-cycle word is not counted.
  - A word with both err_corrected and crc_fail increments both counters.
- Flags clear to 0 on the OUT→IDLE transition.

Decomposition:
- Package edac_pkg holds:
  - the state enum
  - the parity bit index list {0,1,3,7,15}
  - the data bit index map
  - HAM_W=21 and DATA_W=8
  - the crc_step function (one division step), shared with any future encoder rework
- Sub-module edac_syndrome: combinational; din[20:0] → syndrome[4:0], corrected[20:0], err_corrected, err_uncorrectable. Instantiated once, its outputs registered in SYND.

Test Plan:
1. Clean word: din=32'h0000_10F1, crc_poly=8'h07 → after 10 cycles dout=8'h01, all flags 0, counters unchanged.
2. Single error: din=32'h0000_00F1 (bit 12 flipped), poly 8'h07 → s=13, dout=8'h01, err_corrected=1, crc_fail=0, cnt_corr=1.
3. Double error miscorrection: din=32'h0000_10F2 (bits 0,1 flipped), poly 8'h07 → s=3, bit 2 flipped, dout=8'h01, err_corrected=1, crc_fail=1, cnt_corr+1, cnt_uncorr+1.
4. Uncorrectable: din=32'h0010_10F3 (bits 1,20 flipped) → s=23, err_uncorrectable=1, dout=8'h81 (I[15] flipped, uncorrected), cnt_uncorr+1.
5. Backpressure: hold dout_ready=0 for 20 cycles in OUT → dout and flags stable, din_ready=0, second din_valid ignored. Release → handshake completes, next word is accepted the following cycle.
6. Reset and saturation:
   - Assert rst_n=0 during CRC → dout_valid=0 and din_ready=1 immediately.
   - Preload via 65 535 corrected words, then one more → cnt_corr stays 16'hFFFF.
   - clr_cnt concurrent with a handshake → counter reads 0.

Source files
------------

// File: rtl/edac_pkg.sv
// edac_pkg: shared Hamming(21,16) layout, FSM states and CRC division step for the EDAC path.
package edac_pkg;
    localparam int HAM_W = 21;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {IDLE, SYND, CRC, OUT} state_t;

    // Parity bit j lives at word bit 2**j - 1; data bits fill the remaining slots in ascending order
    localparam logic [4:0][4:0] PAR_IDX = {5'd15, 5'd7, 5'd3, 5'd1, 5'd0};
    localparam logic [15:0][4:0] DATA_IDX = {
        5'd20, 5'd19, 5'd18, 5'd17, 5'd16, 5'd14, 5'd13, 5'd12,
        5'd11, 5'd10, 5'd9, 5'd8, 5'd6, 5'd5, 5'd4, 5'd2
    };

    function automatic logic [15:0] extract(input logic [HAM_W-1:0] w);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[i] = w[DATA_IDX[i]];
        return r;
    endfunction

    // Step s handles dividend bit k = 15 - s, aligning the polynomial at shift k - 7
    function automatic logic [15:0] crc_step(input logic [15:0] t, input logic [DATA_W-1:0] poly,
                                             input logic [2:0] step);
        logic [3:0] k;
        k = 4'd15 - {1'b0, step};
        return t[k] ? t ^ ({8'h00, poly} << (4'd8 - {1'b0, step})) : t;
    endfunction
endpackage

// File: rtl/edac_syndrome.sv
// edac_syndrome: combinational Hamming(21,16) syndrome and single-bit correction.
module edac_syndrome
    import edac_pkg::*;
(
    input  logic [HAM_W-1:0] ham,
    output logic [4:0]       syndrome,
    output logic [HAM_W-1:0] corrected,
    output logic             err_corrected,
    output logic             err_uncorrectable
);
    logic [4:0] pos;

    // Each syndrome bit is the stored parity bit XOR the parity recomputed over its data group
    always_comb begin
        syndrome = '0;
        pos = '0;
        for (int j = 0; j < 5; j++) begin
            syndrome[j] = ham[PAR_IDX[j]];
            for (int i = 0; i < 16; i++) begin
                pos = DATA_IDX[i] + 5'd1;
                syndrome[j] = syndrome[j] ^ (pos[j] & ham[DATA_IDX[i]]);
            end
        end
    end

    assign err_corrected = (syndrome != 5'd0) && (syndrome <= 5'd21);
    assign err_uncorrectable = syndrome >= 5'd22;
    assign corrected = err_corrected ? ham ^ (21'(1) << (syndrome - 5'd1)) : ham;
endmodule

// File: rtl/edac_decoder.sv
// edac_decoder: corrects Hamming(21,16) codewords, re-checks the embedded CRC bit-serially
// and hands the payload byte, status flags and saturating error counts to a ready/valid consumer.
module edac_decoder #(
    parameter int CNT_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic [31:0]       din,
    input  logic [DATA_W-1:0] crc_poly,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [DATA_W-1:0] dout,
    output logic              err_corrected,
    output logic              err_uncorrectable,
    output logic              crc_fail,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  cnt_corr,
    output logic [CNT_W-1:0]  cnt_uncorr
);
    import edac_pkg::*;

    state_t            state;
    logic [HAM_W-1:0]  ham_q;
    logic [7:0]        poly_q;
    logic [7:0]        crc_rx_q;
    logic [15:0]       t_q;
    logic [2:0]        step_q;
    logic [4:0]        syn;
    logic [HAM_W-1:0]  corr_w;
    logic              syn_corr;
    logic              syn_unc;
    logic [15:0]       info;
    logic [15:0]       t_next;
    logic              hs;
    logic              unused_bits;

    edac_syndrome u_syn (
        .ham               (ham_q),
        .syndrome          (syn),
        .corrected         (corr_w),
        .err_corrected     (syn_corr),
        .err_uncorrectable (syn_unc)
    );

    assign info = extract(corr_w);
    assign t_next = crc_step(t_q, poly_q, step_q);
    assign din_ready = state == IDLE;
    assign dout_valid = state == OUT;
    assign hs = dout_valid & dout_ready;
    assign unused_bits = ^{din[31:HAM_W], syn};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ham_q <= '0;
            poly_q <= '0;
            crc_rx_q <= '0;
            t_q <= '0;
            step_q <= '0;
            dout <= '0;
            err_corrected <= 1'b0;
            err_uncorrectable <= 1'b0;
            crc_fail <= 1'b0;
        end else begin
            case (state)
                IDLE: if (din_valid) begin
                    ham_q <= din[HAM_W-1:0];
                    poly_q <= crc_poly;
                    state <= SYND;
                end
                SYND: begin
                    dout <= info[15:8];
                    crc_rx_q <= info[7:0];
                    t_q <= {info[15:8], 8'h00};
                    step_q <= '0;
                    err_corrected <= syn_corr;
                    err_uncorrectable <= syn_unc;
                    state <= CRC;
                end
                CRC: begin
                    t_q <= t_next;
                    step_q <= step_q + 3'd1;
                    if (step_q == 3'd7) begin
                        crc_fail <= t_next[7:0] != crc_rx_q;
                        state <= OUT;
                    end
                end
                OUT: if (dout_ready) begin
                    err_corrected <= 1'b0;
                    err_uncorrectable <= 1'b0;
                    crc_fail <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Clear outranks a coinciding handshake, so that word is never counted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_corr <= '0;
            cnt_uncorr <= '0;
        end else begin
            cnt_corr <= clr_cnt ? '0 :
                        (hs && err_corrected && !(&cnt_corr)) ? cnt_corr + CNT_W'(1) : cnt_corr;
            cnt_uncorr <= clr_cnt ? '0 :
                          (hs && (err_uncorrectable || crc_fail) && !(&cnt_uncorr)) ?
                          cnt_uncorr + CNT_W'(1) : cnt_uncorr;
        end
    end
endmodule

// File: tb/tb_edac_decoder.sv
// tb_edac_decoder: directed vectors with hand-computed results for edac_decoder.
// Counters are narrowed to 4 bits so saturation is reachable in a short run.
module tb_edac_decoder;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          din_valid = 1'b0;
    logic          din_ready;
    logic [31:0]   din = '0;
    logic [7:0]    crc_poly = 8'h07;
    logic          dout_valid;
    logic          dout_ready = 1'b0;
    logic [7:0]    dout;
    logic          err_corrected;
    logic          err_uncorrectable;
    logic          crc_fail;
    logic          clr_cnt = 1'b0;
    logic [CW-1:0] cnt_corr;
    logic [CW-1:0] cnt_uncorr;

    int vectors = 0;
    int errs = 0;
    int lat;
    logic stable;

    edac_decoder #(.CNT_W(CW), .DATA_W(8)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .din_valid         (din_valid),
        .din_ready         (din_ready),
        .din               (din),
        .crc_poly          (crc_poly),
        .dout_valid        (dout_valid),
        .dout_ready        (dout_ready),
        .dout              (dout),
        .err_corrected     (err_corrected),
        .err_uncorrectable (err_uncorrectable),
        .crc_fail          (crc_fail),
        .clr_cnt           (clr_cnt),
        .cnt_corr          (cnt_corr),
        .cnt_uncorr        (cnt_uncorr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Edges counted from the accepting edge (which counts as 1) until dout_valid is seen
    task automatic wait_valid(output int n);
        n = 1;
        while (n < 30) begin
            @(posedge clk);
            n++;
            #1;
            if (dout_valid) break;
        end
    endtask

    task automatic run_word(input logic [31:0] w, input logic [7:0] p, output int n);
        int g;
        g = 0;
        @(negedge clk);
        din = w;
        crc_poly = p;
        din_valid = 1'b1;
        while (!din_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        #1 din_valid = 1'b0;
        wait_valid(n);
    endtask

    task automatic ack(input logic clr);
        @(negedge clk);
        dout_ready = 1'b1;
        clr_cnt = clr;
        @(posedge clk);
        #1;
        dout_ready = 1'b0;
        clr_cnt = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_din_ready", 32'(din_ready), 32'd1);
        chk("rst_dout_valid", 32'(dout_valid), 32'd0);
        chk("rst_dout", 32'(dout), 32'h00);
        chk("rst_flags", 32'({err_corrected, err_uncorrectable, crc_fail}), 32'd0);
        chk("rst_cnts", 32'({cnt_corr, cnt_uncorr}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_word(32'h0000_10F1, 8'h07, lat);
        chk("clean_latency", 32'(lat), 32'd10);
        chk("clean_dout", 32'(dout), 32'h01);
        chk("clean_flags", 32'({err_corrected, err_uncorrectable, crc_fail}), 32'b000);
        ack(1'b0);
        chk("clean_cnts", 32'({cnt_corr, cnt_uncorr}), 32'h00);

        run_word(32'h0000_00F1, 8'h07, lat);
        chk("single_dout", 32'(dout), 32'h01);
        chk("single_flags", 32'({err_corrected, err_uncorrectable, crc_fail}), 32'b100);
        ack(1'b0);
        chk("single_flags_clr", 32'({err_corrected, err_uncorrectable, crc_fail}), 32'b000);
        chk("single_cnt_corr", 32'(cnt_corr), 32'd1);

        run_word(32'h0000_10F2, 8'h07, lat);
        chk("double_dout", 32'(dout), 32'h01);
        chk("double_flags", 32'({err_corrected, err_uncorrectable, crc_fail}), 32'b101);
        ack(1'b0);
        chk("double_cnts", 32'({cnt_corr, cnt_uncorr}), {24'd0, 4'd2, 4'd1});

        run_word(32'h0010_10F3, 8'h07, lat);
        chk("uncorr_dout", 32'(dout), 32'h81);
        chk("uncorr_flags", 32'({err_corrected, err_uncorrectable, crc_fail}), 32'b011);
        ack(1'b0);
        chk("uncorr_cnts", 32'({cnt_corr, cnt_uncorr}), {24'd0, 4'd2, 4'd2});

        run_word(32'h0000_10F1, 8'h07, lat);
        @(negedge clk);
        din = 32'h0000_00F1;
        din_valid = 1'b1;
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (dout !== 8'h01 || dout_valid !== 1'b1 || din_ready !== 1'b0 ||
                {err_corrected, err_uncorrectable, crc_fail} !== 3'b000) stable = 1'b0;
        end
        chk("bp_stable", 32'(stable), 32'd1);
        @(negedge clk);
        dout_ready = 1'b1;
        @(posedge clk);
        #1 dout_ready = 1'b0;
        chk("bp_release_idle", 32'({din_ready, dout_valid}), 32'b10);
        @(posedge clk);
        #1 din_valid = 1'b0;
        chk("bp_next_accepted", 32'(din_ready), 32'd0);
        wait_valid(lat);
        chk("bp_next_latency", 32'(lat), 32'd10);
        chk("bp_next_dout", 32'(dout), 32'h01);
        chk("bp_next_corr", 32'(err_corrected), 32'd1);
        ack(1'b0);
        chk("bp_cnts", 32'({cnt_corr, cnt_uncorr}), {24'd0, 4'd3, 4'd2});

        @(negedge clk);
        din = 32'h0000_10F1;
        din_valid = 1'b1;
        @(posedge clk);
        #1 din_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready_valid", 32'({din_ready, dout_valid}), 32'b10);
        chk("midrst_cnts", 32'({cnt_corr, cnt_uncorr}), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1 chk("midrst_no_output", 32'(dout_valid), 32'd0);

        for (int i = 0; i < 15; i++) begin
            run_word(32'h0000_00F1, 8'h07, lat);
            ack(1'b0);
        end
        chk("sat_reach", 32'(cnt_corr), 32'hF);
        run_word(32'h0000_00F1, 8'h07, lat);
        ack(1'b0);
        chk("sat_hold", 32'(cnt_corr), 32'hF);
        chk("sat_uncorr", 32'(cnt_uncorr), 32'h0);

        run_word(32'h0000_00F1, 8'h07, lat);
        ack(1'b1);
        chk("clr_with_hs", 32'(cnt_corr), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
